// File: rtl/gru_pkg.sv
// rtl/gru_pkg.sv - shared constants, FSM encoding and slice helper for the GRU hidden-state update
package gru_pkg;

  localparam logic [31:0] FP_ONE      = 32'h3F800000;
  localparam int          FP_SIGN_BIT = 31;
  localparam int          ADD_LATENCY = 2;
  localparam int          MUL_LATENCY = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_SUB,
    S_SUB_WAIT,
    S_SUB_IDLE,
    S_MUL,
    S_MUL_WAIT,
    S_MUL_IDLE,
    S_ADD,
    S_ADD_WAIT,
    S_ADD_IDLE,
    S_NEXT,
    S_DONE
  } state_t;

  // Bit offset of element idx inside a flat vector of single-precision words.
  function automatic int unsigned elem_lsb(input int unsigned idx);
    return idx * 32;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - single-precision adder (value_in + bias) behind a level start/done handshake
module adder
  import gru_pkg::*;
#(
  parameter int LATENCY = ADD_LATENCY
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] value_in,
  input  logic [31:0] bias,
  output logic        done,
  output logic [31:0] value_out
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;
  logic          done_q;

  // Round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  diff;
    logic [26:0] mx, my, sh;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] rnd;
    logic        found;
    int          lz;
    if (a[30:23] == 8'hFF) begin
      if (b[30:23] == 8'hFF && a[22:0] == 23'd0 && b[22:0] == 23'd0 && a[31] != b[31])
        return 32'h7FC00000;
      return a;
    end
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    diff = x[30:23] - y[30:23];
    mx   = {1'b1, x[22:0], 3'b000};
    my   = {1'b1, y[22:0], 3'b000};
    if (diff > 8'd26) begin
      sh = 27'd1;
    end else begin
      sh    = my >> diff;
      sh[0] = sh[0] | (|(my & ((27'd1 << diff) - 27'd1)));
    end
    e = {2'b00, x[30:23]};
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, sh};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'd1;
      end
    end else begin
      sum = {1'b0, mx} - {1'b0, sh};
      if (sum == 28'd0) return 32'h00000000;
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz++;
        end
      end
      sum = sum << lz;
      e   = e - 10'(lz);
    end
    if (e[9] || e == 10'd0) return {x[31], 31'd0};
    rnd = {1'b0, sum[26:3]} + 25'(sum[2] & (sum[1] | sum[0] | sum[3]));
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], rnd[22:0]};
  endfunction

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt       <= '0;
      done_q    <= 1'b0;
      value_out <= '0;
    end else if (!start) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (cnt == CW'(LATENCY - 1)) begin
        done_q    <= 1'b1;
        value_out <= fp_add(value_in, bias);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // done follows start down in the same cycle so the caller's idle check costs one cycle.
  assign done = done_q & start;

endmodule

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - single-precision multiplier behind a level start/done handshake
module fp_multiplier
  import gru_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] product
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;
  logic          done_q;

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, x_zero, y_zero, x_inf, y_inf, g, st;
    logic [47:0] p;
    logic [23:0] m;
    logic [9:0]  e;
    logic [24:0] rnd;
    s      = x[31] ^ y[31];
    x_zero = (x[30:23] == 8'd0);
    y_zero = (y[30:23] == 8'd0);
    x_inf  = (x[30:23] == 8'hFF);
    y_inf  = (y[30:23] == 8'hFF);
    if ((x_inf && x[22:0] != 23'd0) || (y_inf && y[22:0] != 23'd0)) return 32'h7FC00000;
    if (x_inf || y_inf) begin
      if (x_zero || y_zero) return 32'h7FC00000;
      return {s, 8'hFF, 23'd0};
    end
    if (x_zero || y_zero) return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = 10'(x[30:23]) + 10'(y[30:23]) - 10'd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    rnd = {1'b0, m} + 25'(g & (st | m[0]));
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'd1;
    end
    if (e[9] || e == 10'd0) return {s, 31'd0};
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], rnd[22:0]};
  endfunction

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt     <= '0;
      done_q  <= 1'b0;
      product <= '0;
    end else if (!start) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (cnt == CW'(LATENCY - 1)) begin
        done_q  <= 1'b1;
        product <= fp_mul(a, b);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign done = done_q & start;

endmodule

// File: rtl/gru_hidden_update.sv
// rtl/gru_hidden_update.sv - h_t = n + z*(h_prev - n) per element, sharing one adder and one multiplier
module gru_hidden_update
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GRU_UNITS  = 7
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  output logic                            done,
  input  logic [GRU_UNITS*DATA_WIDTH-1:0] i_z_vector_flat,
  input  logic [GRU_UNITS*DATA_WIDTH-1:0] i_n_vector_flat,
  input  logic [GRU_UNITS*DATA_WIDTH-1:0] i_h_prev_flat,
  output logic [GRU_UNITS*DATA_WIDTH-1:0] o_h_new_flat
);

  localparam int IDX_W = $clog2(GRU_UNITS + 1);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [GRU_UNITS*DATA_WIDTH-1:0] z_q, n_q, h_q;
  logic [31:0]                     z_e, n_e, h_e, d_q, p_q;
  logic [31:0]                     add_a, add_b, add_y, mul_y;
  logic                            add_start, add_done, mul_start, mul_done;

  assign z_e = z_q[elem_lsb(32'(idx)) +: 32];
  assign n_e = n_q[elem_lsb(32'(idx)) +: 32];
  assign h_e = h_q[elem_lsb(32'(idx)) +: 32];

  // The adder serves both h_prev - n (sign-flipped n) and the final n + p.
  always_comb begin
    add_a = h_e;
    add_b = {~n_e[FP_SIGN_BIT], n_e[FP_SIGN_BIT-1:0]};
    if (state == S_ADD || state == S_ADD_WAIT || state == S_ADD_IDLE) begin
      add_a = n_e;
      add_b = p_q;
    end
  end

  adder #(.LATENCY(ADD_LATENCY)) u_adder (
    .clk       (clk),
    .rstn      (rstn),
    .start     (add_start),
    .value_in  (add_a),
    .bias      (add_b),
    .done      (add_done),
    .value_out (add_y)
  );

  fp_multiplier #(.LATENCY(MUL_LATENCY)) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .start   (mul_start),
    .a       (z_e),
    .b       (d_q),
    .done    (mul_done),
    .product (mul_y)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state        <= S_IDLE;
      idx          <= '0;
      z_q          <= '0;
      n_q          <= '0;
      h_q          <= '0;
      d_q          <= '0;
      p_q          <= '0;
      add_start    <= 1'b0;
      mul_start    <= 1'b0;
      done         <= 1'b0;
      o_h_new_flat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            z_q   <= i_z_vector_flat;
            n_q   <= i_n_vector_flat;
            h_q   <= i_h_prev_flat;
            idx   <= '0;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // z of exactly 0 or 1 selects an input directly, skipping the arithmetic.
          if (z_e[30:0] == 31'd0) begin
            o_h_new_flat[elem_lsb(32'(idx)) +: 32] <= n_e;
            state <= S_NEXT;
          end else if (z_e == FP_ONE) begin
            o_h_new_flat[elem_lsb(32'(idx)) +: 32] <= h_e;
            state <= S_NEXT;
          end else begin
            state <= S_SUB;
          end
        end
        S_SUB: begin
          add_start <= 1'b1;
          state     <= S_SUB_WAIT;
        end
        S_SUB_WAIT: begin
          if (add_done) begin
            d_q       <= add_y;
            add_start <= 1'b0;
            state     <= S_SUB_IDLE;
          end
        end
        S_SUB_IDLE: if (!add_done) state <= S_MUL;
        S_MUL: begin
          mul_start <= 1'b1;
          state     <= S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (mul_done) begin
            p_q       <= mul_y;
            mul_start <= 1'b0;
            state     <= S_MUL_IDLE;
          end
        end
        S_MUL_IDLE: if (!mul_done) state <= S_ADD;
        S_ADD: begin
          add_start <= 1'b1;
          state     <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (add_done) begin
            o_h_new_flat[elem_lsb(32'(idx)) +: 32] <= add_y;
            add_start <= 1'b0;
            state     <= S_ADD_IDLE;
          end
        end
        S_ADD_IDLE: if (!add_done) state <= S_NEXT;
        S_NEXT: begin
          if (idx == IDX_W'(GRU_UNITS - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_CHECK;
          end
        end
        S_DONE: begin
          // done is raised first, then held until start is seen low.
          if (!done) begin
            done <= 1'b1;
          end else if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_hidden_update.sv
// tb/tb_gru_hidden_update.sv - randomized scoreboard bench for gru_hidden_update
module tb_gru_hidden_update;
  import gru_pkg::*;

  localparam int U = 7;
  localparam int W = 32;
  localparam logic [31:0] ONE_BITS = 32'h3F800000;

  typedef struct {
    logic [U*W-1:0] vec;
    int             lat;
  } exp_t;

  logic           clk, rstn, start, done;
  logic [U*W-1:0] z_in, n_in, h_in, o_h;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rises = 0;
  logic start_d = 1'b0;
  logic prev_done = 1'b0;

  gru_hidden_update #(.DATA_WIDTH(W), .GRU_UNITS(U)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .done            (done),
    .i_z_vector_flat (z_in),
    .i_n_vector_flat (n_in),
    .i_h_prev_flat   (h_in),
    .o_h_new_flat    (o_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real b2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2b(input real x);
    logic [63:0] d;
    if (x == 0.0) return 32'd0;
    d = $realtobits(x);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic bit is_bypass(input logic [31:0] z);
    return (z[30:0] == 31'd0) || (z == ONE_BITS);
  endfunction

  function automatic logic [31:0] model_elem(input logic [31:0] z, input logic [31:0] n, input logic [31:0] h);
    if (z[30:0] == 31'd0) return n;
    if (z == ONE_BITS) return h;
    return r2b(b2r(n) + b2r(z) * (b2r(h) - b2r(n)));
  endfunction

  task automatic chk_vec(input string name, input logic [U*W-1:0] act, input logic [U*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic issue(input logic [U*W-1:0] z, input logic [U*W-1:0] n, input logic [U*W-1:0] h,
                       input bit scramble);
    exp_t e;
    e.lat = 2;
    for (int i = 0; i < U; i++) begin
      e.vec[i*W +: W] = model_elem(z[i*W +: W], n[i*W +: W], h[i*W +: W]);
      e.lat += is_bypass(z[i*W +: W]) ? 2 : 11 + 2 * ADD_LATENCY + MUL_LATENCY;
    end
    exp_q.push_back(e);
    @(negedge clk);
    z_in  = z;
    n_in  = n;
    h_in  = h;
    start = 1'b1;
    if (scramble) begin
      @(negedge clk);
      for (int i = 0; i < U; i++) begin
        z_in[i*W +: W] = $urandom();
        n_in[i*W +: W] = $urandom();
        h_in[i*W +: W] = $urandom();
      end
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: done never rose, got 0, expected 1", name);
    end
  endtask

  task automatic finish_run(input string name);
    start = 1'b0;
    @(negedge clk);
    chk_int({name, "_done_drop"}, int'(done), 0);
  endtask

  function automatic logic [U*W-1:0] fill(input logic [31:0] v);
    logic [U*W-1:0] r;
    for (int i = 0; i < U; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    return r2b(real'(int'($urandom_range(32)) - 16) / 4.0);
  endfunction

  function automatic logic [31:0] rand_z();
    int k;
    k = int'($urandom_range(17));
    if (k == 17) return 32'h80000000;
    return r2b(real'(k) / 16.0);
  endfunction

  // Cycle counter restarts on each rising edge of start (counting that edge).
  initial begin
    forever begin
      @(posedge clk);
      if (start && !start_d) cyc = 1;
      else                   cyc = cyc + 1;
      start_d = start;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        rises++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending run");
        end else begin
          e = exp_q.pop_front();
          chk_vec("h_new", o_h, e.vec);
          chk_int("latency", cyc, e.lat);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    logic [U*W-1:0] z, n, h;
    int r0;
    rstn  = 1'b1;
    start = 1'b0;
    z_in  = '0;
    n_in  = '0;
    h_in  = '0;
    repeat (2) @(negedge clk);
    chk_int("reset_done", int'(done), 0);
    chk_vec("reset_out", o_h, '0);
    rstn = 1'b0;

    issue(fill(32'h3F000000), fill(32'h3F800000), fill(32'h00000000), 1'b0);
    wait_done("half");
    finish_run("half");

    issue(fill(32'h3E800000), fill(32'hBF800000), fill(32'h3F800000), 1'b0);
    wait_done("quarter");
    finish_run("quarter");

    z = fill(32'h3F000000);
    z[0*W +: W] = 32'h00000000;
    z[1*W +: W] = 32'h80000000;
    z[2*W +: W] = 32'h3F800000;
    for (int i = 0; i < U; i++) begin
      n[i*W +: W] = rand_val();
      h[i*W +: W] = rand_val();
    end
    issue(z, n, h, 1'b0);
    wait_done("mixed");
    finish_run("mixed");

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < U; i++) begin
        z[i*W +: W] = rand_z();
        n[i*W +: W] = rand_val();
        h[i*W +: W] = rand_val();
      end
      issue(z, n, h, 1'b1);
      wait_done("random");
      finish_run("random");
    end

    issue(fill(32'h3F400000), fill(32'h40000000), fill(32'hC0000000), 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done("drop");
    @(negedge clk);
    chk_int("drop_done_one_cycle", int'(done), 0);

    r0 = rises;
    issue(fill(32'h3F000000), fill(32'h3F800000), fill(32'h40400000), 1'b0);
    wait_done("hold");
    repeat (20) @(negedge clk);
    chk_int("hold_done_high", int'(done), 1);
    chk_int("hold_no_retrigger", rises, r0 + 1);
    finish_run("hold");

    issue(fill(32'h3F000000), fill(32'h40000000), fill(32'h3F800000), 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_int("midreset_done", int'(done), 0);
    chk_vec("midreset_out", o_h, '0);
    void'(exp_q.pop_back());
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b0;

    issue(fill(32'h3F000000), fill(32'h3F800000), fill(32'h00000000), 1'b1);
    wait_done("after_reset");
    finish_run("after_reset");

    repeat (5) @(negedge clk);
    chk_int("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gru_hidden_update.md
# gru_hidden_update

Final per-timestep stage of the GRU cell, directly downstream of the gate calculator. It consumes the update-gate vector z (sigmoid outputs), the candidate vector n (tanh outputs) and the previous hidden state. It computes h_t[i] = n[i] + z[i]·(h_prev[i] − n[i]) element-by-element in IEEE-754 single precision. One shared adder and one multiplier are time-multiplexed across the GRU_UNITS elements, and the block reports completion with the team's level start/done handshake.

## Interface
- DATA_WIDTH, 32, element width; IEEE-754 single only, other values unsupported
- GRU_UNITS, 7, hidden vector length (1..15)
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-high (asserted = 1, despite the name)
- start  in  1  level request; held high until done seen, then dropped
- done  out  1  level; high from result-valid until start low
- i_z_vector_flat  in  GRU_UNITS·DATA_WIDTH  update gate z, element i at [i·32 +: 32]
- i_n_vector_flat  in  GRU_UNITS·DATA_WIDTH  candidate n
- i_h_prev_flat  in  GRU_UNITS·DATA_WIDTH  previous hidden state
- o_h_new_flat  out  GRU_UNITS·DATA_WIDTH  new hidden state, registered

## Operation
- Reset: state S_IDLE, done=0, o_h_new_flat=0, all internal start strobes 0, latched vectors 0, element index 0.
- S_IDLE: when start=1, latch all three input vectors and set idx=0 → S_CHECK. Inputs may change freely after the latch.
- S_CHECK inspects z[idx]:
  - z = +0 or −0: write n[idx] → S_NEXT (bypass).
  - z = 0x3F800000 (1.0): write h_prev[idx] → S_NEXT (bypass).
  - Otherwise → S_SUB.
- S_SUB / S_SUB_WAIT / S_SUB_IDLE: adder computes d = h_prev + (n with bit 31 inverted). Hold the adder start high until its done. Latch d, drop start, and wait for adder done low.
- S_MUL / S_MUL_WAIT / S_MUL_IDLE: multiplier computes p = z·d with the same hold/latch/wait pattern.
- S_ADD / S_ADD_WAIT / S_ADD_IDLE: adder computes r = n + p. Write r into o_h_new_flat slot idx.
- S_NEXT: if idx = GRU_UNITS−1 → S_DONE, else idx+1 → S_CHECK.
- S_DONE: done=1. When start=0, done=0 → S_IDLE.
- start falling mid-computation is ignored: the computation completes and done pulses for at least one cycle. start held high after S_DONE does not retrigger; a new run needs start low then high.
- Output slots not yet rewritten in the current run keep their previous values. The full vector is valid only while done=1.
- NaN/Inf are passed through the arithmetic units unmodified; no special handling.

## Timing
- Sub-unit handshake: start is level and held until done. done stays high until start is low. Sub-unit latency is L_add / L_mul cycles from start seen to done.
- Per arithmetic op: 1 start cycle + L + 1 latch cycle + 1 idle-check cycle.
- Per element:
  - bypass: 2 cycles (S_CHECK, S_NEXT).
  - full: 2 + 3·3 + 2·L_add + L_mul cycles.
- Total, start high to done high: 1 + Σ per-element + 1.
- Reset asserted at any cycle returns every output to its reset value by the next clock edge (asynchronous). Any in-flight sub-unit operation is abandoned because the sub-units share reset.

## Structure
- Shared package gru_pkg: FP_ONE = 32'h3F800000, FP_SIGN_BIT = 31, state encoding localparams, element slice helper.
- Reuse the existing `adder` (value_in + bias) for both the subtract and the final add.
- One natural new sub-module: `fp_multiplier`, with the same start/done/rstn interface as `adder`, inputs a and b, output product.
- Element index width: $clog2(GRU_UNITS+1).

## Test plan
- z=0x3F000000 (0.5), n=0x3F800000 (1.0), h_prev=0 in all slots → every slot 0x3F000000; done rises at the computed latency.
- z=0x3E800000 (0.25), n=0xBF800000 (−1.0), h_prev=0x3F800000 → every slot 0xBF000000 (−0.5).
- Mixed z per slot {0, 0x80000000, 0x3F800000, 0.5, …} → slots 0–1 equal n exactly, slot 2 equals h_prev exactly. Bypassed slots cost 2 cycles each and the adder start never pulses for them.
- Drop start mid-run → run completes, done high for exactly 1 cycle, then S_IDLE. Hold start high after done → done stays 1 and no second run occurs.
- Assert rstn mid-multiply → done=0, o_h_new_flat=0 immediately. After release, a new start gives correct results.
- Change inputs one cycle after start → outputs reflect the latched (original) vectors.
